cheat_codes: RTL and testbench

Game Genie / Pro Action Replay style cheat engine that sits directly downstream of the top-level cheat-code loader and inside the ROM read path of `system`. It captures 129-bit code words strobed in by the loader and stores up to `MAX_CODES` entries. On each CPU ROM read whose address matches a stored entry, it substitutes the replacement byte for the ROM byte, optionally only when the ROM byte equals a compare value.

---
 rtl/cheat_codes.sv | 164 ++++++++++++++++
 tb/tb_cheat_codes.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cheat_codes.sv
`default_nettype none
// ============================================================================
// Module   : cheat_codes
// Purpose  : Cheat-code table in the ROM read path; substitutes ROM bytes on
//            address hits. Define CHEAT_COMPARE_EN for compare-gated replacement.
// Revision : 1.0 - initial release
// ============================================================================
module cheat_codes #(
    parameter int MAX_CODES = 32,
    parameter int ADDR_W    = 16
) (
    input  logic              clk_sys,
    input  logic              RESET_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [128:0]      code,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              available,
    output logic              full
);
    localparam int c_idx_w = (MAX_CODES > 1) ? $clog2(MAX_CODES) : 1;
    localparam int c_cnt_w = $clog2(MAX_CODES + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_CODES);

    logic              valid_q      [MAX_CODES];
    logic              valid_d      [MAX_CODES];
    logic [ADDR_W-1:0] entry_addr_q [MAX_CODES];
    logic [ADDR_W-1:0] entry_addr_d [MAX_CODES];
    logic [7:0]        rep_q        [MAX_CODES];
    logic [7:0]        rep_d        [MAX_CODES];
`ifdef CHEAT_COMPARE_EN
    logic              cmp_en_q     [MAX_CODES];
    logic              cmp_en_d     [MAX_CODES];
    logic [7:0]        cmp_q        [MAX_CODES];
    logic [7:0]        cmp_d        [MAX_CODES];
`endif

    logic [c_cnt_w-1:0] count_q, count_d;
    logic               available_q, available_d;
    logic               full_q, full_d;
    logic               hit_q, hit_d;
    logic [c_idx_w-1:0] hit_idx_q, hit_idx_d;

    logic [ADDR_W-1:0]  ld_addr;
    logic               ld_hit;
    logic [c_idx_w-1:0] ld_idx;
    logic               lk_hit;
    logic [c_idx_w-1:0] lk_idx;

    // Reserved flag bits and unused compare/address bits are deliberately dropped.
    logic unused_code;
    assign unused_code = ^code;

    // Descending scans leave the lowest matching index in the result.
    always_comb begin
        ld_addr = code[64 +: ADDR_W];
        ld_hit  = 1'b0;
        ld_idx  = '0;
        lk_hit  = 1'b0;
        lk_idx  = '0;
        for (int i = MAX_CODES - 1; i >= 0; i--) begin
            if (valid_q[i] && (entry_addr_q[i] == ld_addr)) begin
                ld_hit = 1'b1;
                ld_idx = c_idx_w'(i);
            end
            if (valid_q[i] && (entry_addr_q[i] == addr)) begin
                lk_hit = 1'b1;
                lk_idx = c_idx_w'(i);
            end
        end
    end

    always_comb begin
        valid_d      = valid_q;
        entry_addr_d = entry_addr_q;
        rep_d        = rep_q;
`ifdef CHEAT_COMPARE_EN
        cmp_en_d     = cmp_en_q;
        cmp_d        = cmp_q;
`endif
        count_d      = count_q;
        if (clear) begin
            for (int i = 0; i < MAX_CODES; i++) begin
                valid_d[i] = 1'b0;
            end
            count_d = '0;
        end else if (code[128]) begin
            // A known address is rewritten in place; a new one appends at count.
            for (int i = 0; i < MAX_CODES; i++) begin
                if (ld_hit ? (ld_idx == c_idx_w'(i)) : (count_q == c_cnt_w'(i))) begin
                    valid_d[i]      = 1'b1;
                    entry_addr_d[i] = ld_addr;
                    rep_d[i]        = code[7:0];
`ifdef CHEAT_COMPARE_EN
                    cmp_en_d[i]     = code[96];
                    cmp_d[i]        = code[39:32];
`endif
                end
            end
            if (!ld_hit && (count_q != c_max_cnt)) begin
                count_d = count_q + c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        available_d = (count_d != '0);
        full_d      = (count_d == c_max_cnt);
        hit_d       = enable && lk_hit && !clear;
        hit_idx_d   = lk_idx;
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            count_q     <= '0;
            available_q <= 1'b0;
            full_q      <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            for (int i = 0; i < MAX_CODES; i++) begin
                valid_q[i]      <= 1'b0;
                entry_addr_q[i] <= '0;
                rep_q[i]        <= '0;
`ifdef CHEAT_COMPARE_EN
                cmp_en_q[i]     <= 1'b0;
                cmp_q[i]        <= '0;
`endif
            end
        end else begin
            count_q      <= count_d;
            available_q  <= available_d;
            full_q       <= full_d;
            hit_q        <= hit_d;
            hit_idx_q    <= hit_idx_d;
            valid_q      <= valid_d;
            entry_addr_q <= entry_addr_d;
            rep_q        <= rep_d;
`ifdef CHEAT_COMPARE_EN
            cmp_en_q     <= cmp_en_d;
            cmp_q        <= cmp_d;
`endif
        end
    end

    always_comb begin
        data_out = data_in;
        if (hit_q) begin
`ifdef CHEAT_COMPARE_EN
            if (!cmp_en_q[hit_idx_q] || (data_in == cmp_q[hit_idx_q])) begin
                data_out = rep_q[hit_idx_q];
            end
`else
            data_out = rep_q[hit_idx_q];
`endif
        end
    end

    assign available = available_q;
    assign full      = full_q;

endmodule
`default_nettype wire

// File: tb/tb_cheat_codes.sv
`default_nettype none
// ============================================================================
// Module   : tb_cheat_codes
// Purpose  : Directed self-checking bench for cheat_codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cheat_codes;
    localparam int N = 32;

    logic         clk_sys;
    logic         RESET_n;
    logic         clear;
    logic         enable;
    logic [128:0] code;
    logic [15:0]  addr;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic         available;
    logic         full;

    int n_asserts;
    int n_fail;

    cheat_codes #(
        .MAX_CODES (N),
        .ADDR_W    (16)
    ) dut (
        .clk_sys   (clk_sys),
        .RESET_n   (RESET_n),
        .clear     (clear),
        .enable    (enable),
        .code      (code),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .available (available),
        .full      (full)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reserved flag bits and upper address bits are set to prove they are ignored.
    task automatic load(input logic [15:0] a, input logic ce, input logic [7:0] c,
                        input logic [7:0] r);
        code           = '0;
        code[128]      = 1'b1;
        code[127:97]   = '1;
        code[96]       = ce;
        code[95:80]    = 16'hFFFF;
        code[79:64]    = a;
        code[39:32]    = c;
        code[7:0]      = r;
        step();
        code           = '0;
    endtask

    initial begin
        logic [7:0] exp_cmp_miss;
        n_asserts = 0;
        n_fail    = 0;
        RESET_n   = 1'b0;
        clear     = 1'b0;
        enable    = 1'b0;
        code      = '0;
        addr      = 16'h1234;
        data_in   = 8'h5A;
        repeat (3) step();
        RESET_n = 1'b1;
        step();
        chk8("reset_passthrough", data_out, 8'h5A);
        chk1("reset_available", available, 1'b0);
        chk1("reset_full", full, 1'b0);

        load(16'h1234, 1'b0, 8'h00, 8'hC9);
        chk1("available_after_load", available, 1'b1);
        chk1("not_full_after_load", full, 1'b0);
        enable  = 1'b1;
        data_in = 8'h00;
        step();
        chk8("replace_c9", data_out, 8'hC9);
        data_in = 8'h5A;
        #1;
        chk8("replace_c9_any_data", data_out, 8'hC9);

`ifdef CHEAT_COMPARE_EN
        exp_cmp_miss = 8'h3F;
`else
        exp_cmp_miss = 8'h00;
`endif
        load(16'h2000, 1'b1, 8'h3E, 8'h00);
        addr = 16'h2000;
        step();
        data_in = 8'h3E;
        #1;
        chk8("cmp_match", data_out, 8'h00);
        data_in = 8'h3F;
        #1;
        chk8("cmp_miss", data_out, exp_cmp_miss);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk1("clear_available", available, 1'b0);
        chk8("clear_drops_hit", data_out, 8'h3F);

        for (int i = 0; i < N; i++) begin
            load(16'h3000 + 16'(i), 1'b0, 8'h00, 8'h80 + 8'(i));
            if (i == N - 2) chk1("not_full_before_last", full, 1'b0);
        end
        chk1("full_after_max", full, 1'b1);
        chk1("available_when_full", available, 1'b1);
        load(16'h3000 + 16'(N), 1'b0, 8'h00, 8'hEE);
        chk1("full_after_drop", full, 1'b1);
        addr    = 16'h3000 + 16'(N);
        data_in = 8'h11;
        step();
        chk8("dropped_passthrough", data_out, 8'h11);
        addr = 16'h3001;
        step();
        chk8("entry1_intact", data_out, 8'h81);
        addr = 16'h3000 + 16'(N - 1);
        step();
        chk8("last_entry", data_out, 8'h80 + 8'(N - 1));

        load(16'h3000, 1'b0, 8'h00, 8'h77);
        addr = 16'h3000;
        step();
        chk8("reload_entry0", data_out, 8'h77);
        chk1("full_count_unchanged", full, 1'b1);
        load(16'h3000, 1'b0, 8'h00, 8'h66);
        chk8("overwrite_while_hit", data_out, 8'h66);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk8("clear_forces_miss", data_out, 8'h11);
        chk1("clear_empties_full", full, 1'b0);

        code        = '0;
        code[128]   = 1'b1;
        code[79:64] = 16'h4000;
        code[7:0]   = 8'h12;
        clear       = 1'b1;
        step();
        clear = 1'b0;
        code  = '0;
        chk1("clear_strobe_available", available, 1'b0);
        chk1("clear_strobe_full", full, 1'b0);
        addr    = 16'h4000;
        data_in = 8'h34;
        step();
        chk8("clear_strobe_passthrough", data_out, 8'h34);

        load(16'h6000, 1'b0, 8'h00, 8'hAB);
        addr = 16'h6000;
        step();
        chk8("enable_hit", data_out, 8'hAB);
        enable = 1'b0;
        step();
        chk8("disable_passthrough", data_out, 8'h34);
        enable = 1'b1;
        step();
        chk8("reenable_hit", data_out, 8'hAB);

        data_in = 8'h21;
        #1;
        chk8("hit_before_reset", data_out, 8'hAB);
        #1;
        RESET_n = 1'b0;
        #1;
        chk8("async_reset_passthrough", data_out, 8'h21);
        chk1("async_reset_available", available, 1'b0);
        step();
        @(negedge clk_sys);
        RESET_n = 1'b1;
        step();
        chk8("post_reset_empty", data_out, 8'h21);
        chk1("post_reset_available", available, 1'b0);
        load(16'h6000, 1'b0, 8'h00, 8'h5C);
        chk1("post_reset_load_available", available, 1'b1);
        step();
        chk8("post_reset_load_hit", data_out, 8'h5C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
